// File: rtl/ingress_pkg.sv
// Shared helpers for the ingress VOQ controller: width derivation and
// extraction of the destination field from a metadata word.
package ingress_pkg;

  localparam int unsigned MAX_META_W = 256;
  localparam int unsigned MAX_PW     = 8;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One extra bit so a completely full queue (count == depth) is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  // Callers zero-extend the word and pass shift = META_WIDTH - PW, then keep the low PW bits.
  function automatic logic [MAX_PW-1:0] dest_of(input logic [MAX_META_W-1:0] meta,
                                                input int unsigned shift);
    return MAX_PW'(meta >> shift);
  endfunction

endpackage

// File: rtl/voq_sram.sv
// Simple dual-port storage for all VOQs; registered read, one cycle latency.
// Only the read-data register is reset; the array itself is not.
module voq_sram #(
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned WIDTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Holding rdata when idle gives the crossbar a stable last-popped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ingress_voq_ctrl.sv
// Ingress VOQ controller: sorts metadata into per-egress queues in one
// partitioned memory and pops one word per scheduler grant.
module ingress_voq_ctrl
  import ingress_pkg::*;
#(
  parameter  int unsigned PORT_CNT   = 4,
  parameter  int unsigned VOQ_DEPTH  = 256,
  parameter  int unsigned META_WIDTH = 32,
  parameter  int unsigned DROP_CNT_W = 16,
  localparam int unsigned PW = ptr_w(PORT_CNT),
  localparam int unsigned AW = ptr_w(VOQ_DEPTH),
  localparam int unsigned CW = cnt_w(VOQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [META_WIDTH-1:0]    ingress_in,
  input  logic                     ingress_in_en,
  input  logic                     sched_en,
  input  logic [PW-1:0]            sched_sel,
  input  logic                     flush,
  output logic                     ingress_out_en,
  output logic [META_WIDTH-1:0]    ingress_out,
  output logic [PORT_CNT-1:0]      is_empty,
  output logic [PORT_CNT-1:0]      is_full,
  output logic [PORT_CNT*CW-1:0]   occupancy,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic                     sched_err
);

  logic [AW-1:0] head_q [PORT_CNT];
  logic [AW-1:0] head_d [PORT_CNT];
  logic [AW-1:0] tail_q [PORT_CNT];
  logic [AW-1:0] tail_d [PORT_CNT];
  logic [CW-1:0] count_q [PORT_CNT];
  logic [CW-1:0] count_d [PORT_CNT];
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic err_q, err_d;
  logic out_en_q;

  logic [PW-1:0] dest;
  logic enq_ok, drop_hit, deq_ok, bad_grant;

  assign dest = PW'(dest_of(MAX_META_W'(ingress_in), META_WIDTH - PW));

  always_comb begin
    for (int i = 0; i < PORT_CNT; i++) begin
      is_empty[i]             = (count_q[i] == '0);
      is_full[i]              = (count_q[i] == CW'(VOQ_DEPTH));
      occupancy[i*CW +: CW]   = count_q[i];
    end
  end

  // Grants are fire-and-forget: there is no ready back to the scheduler, a grant
  // either pops (valid pulse next cycle) or is rejected and flagged in sched_err.
  // Full/empty are judged on pre-cycle counts, so there is no same-cycle bypass.
  assign enq_ok    = ingress_in_en && !is_full[dest]      && !flush;
  assign drop_hit  = ingress_in_en &&  is_full[dest]      && !flush;
  assign deq_ok    = sched_en      && !is_empty[sched_sel] && !flush;
  assign bad_grant = sched_en      &&  is_empty[sched_sel] && !flush;

  always_comb begin
    for (int i = 0; i < PORT_CNT; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (enq_ok && (dest == PW'(i)))      tail_d[i] = tail_q[i] + AW'(1);
        if (deq_ok && (sched_sel == PW'(i))) head_d[i] = head_q[i] + AW'(1);
        case ({enq_ok && (dest == PW'(i)), deq_ok && (sched_sel == PW'(i))})
          2'b10:   count_d[i] = count_q[i] + CW'(1);
          2'b01:   count_d[i] = count_q[i] - CW'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (flush) begin
      drop_d = '0;
      err_d  = 1'b0;
    end else begin
      if (drop_hit && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
      if (bad_grant)                  err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PORT_CNT; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      drop_q   <= '0;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      out_en_q <= deq_ok;
    end
  end

  voq_sram #(
    .DEPTH (PORT_CNT * VOQ_DEPTH),
    .WIDTH (META_WIDTH)
  ) u_sram (
    .clk   (clk),
    .rst   (reset),
    .we    (enq_ok),
    .waddr ({dest, tail_q[dest]}),
    .wdata (ingress_in),
    .re    (deq_ok),
    .raddr ({sched_sel, head_q[sched_sel]}),
    .rdata (ingress_out)
  );

  assign ingress_out_en = out_en_q;
  assign drop_cnt       = drop_q;
  assign sched_err      = err_q;

endmodule

// File: tb/tb_ingress_voq_ctrl.sv
// Bench for ingress_voq_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ingress_voq_ctrl;

  localparam int P  = 4;
  localparam int D  = 256;
  localparam int W  = 32;
  localparam int DW = 16;
  localparam int PW = 2;
  localparam int CW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]    ingress_in = '0;
  logic            ingress_in_en = 1'b0;
  logic            sched_en = 1'b0;
  logic [PW-1:0]   sched_sel = '0;
  logic            flush = 1'b0;
  logic            ingress_out_en;
  logic [W-1:0]    ingress_out;
  logic [P-1:0]    is_empty;
  logic [P-1:0]    is_full;
  logic [P*CW-1:0] occupancy;
  logic [DW-1:0]   drop_cnt;
  logic            sched_err;

  ingress_voq_ctrl #(
    .PORT_CNT(P), .VOQ_DEPTH(D), .META_WIDTH(W), .DROP_CNT_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .ingress_in(ingress_in), .ingress_in_en(ingress_in_en),
    .sched_en(sched_en), .sched_sel(sched_sel), .flush(flush),
    .ingress_out_en(ingress_out_en), .ingress_out(ingress_out),
    .is_empty(is_empty), .is_full(is_full), .occupancy(occupancy),
    .drop_cnt(drop_cnt), .sched_err(sched_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] voq_m [P][$];
  int           drop_m = 0;
  bit           err_m = 0;
  bit           en_m = 0;
  logic [W-1:0] out_m = '0;

  always @(posedge clk) begin : model
    int d, s;
    bit full_d, empty_s;
    if (reset) begin
      for (int i = 0; i < P; i++) voq_m[i].delete();
      drop_m = 0; err_m = 0; en_m = 0; out_m = '0;
    end else if (flush) begin
      for (int i = 0; i < P; i++) voq_m[i].delete();
      drop_m = 0; err_m = 0; en_m = 0;
    end else begin
      d = int'(ingress_in[W-1 -: PW]);
      s = int'(sched_sel);
      full_d  = (voq_m[d].size() == D);
      empty_s = (voq_m[s].size() == 0);
      en_m = 0;
      if (sched_en) begin
        if (empty_s) err_m = 1;
        else begin
          out_m = voq_m[s].pop_front();
          en_m  = 1;
        end
      end
      if (ingress_in_en) begin
        if (full_d) begin
          if (drop_m < (1 << DW) - 1) drop_m++;
        end else voq_m[d].push_back(ingress_in);
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < P; i++) begin
        check($sformatf("empty%0d", i), 64'(is_empty[i]), 64'(voq_m[i].size() == 0));
        check($sformatf("full%0d", i), 64'(is_full[i]), 64'(voq_m[i].size() == D));
        check($sformatf("occ%0d", i), 64'(occupancy[i*CW +: CW]), 64'(voq_m[i].size()));
      end
      check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
      check("sched_err", 64'(sched_err), 64'(err_m));
      check("out_en", 64'(ingress_out_en), 64'(en_m));
      check("out_data", 64'(ingress_out), 64'(out_m));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit ien, input logic [W-1:0] din, input bit sen,
                      input logic [PW-1:0] sel, input bit fl);
    ingress_in_en = ien; ingress_in = din; sched_en = sen; sched_sel = sel; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [CW-1:0] occ(input int i);
    return occupancy[i*CW +: CW];
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_empty", 64'(is_empty), 64'h F);
    check("rst_full", 64'(is_full), 64'h0);
    check("rst_occ", 64'(occupancy), 64'h0);
    check("rst_out_en", 64'(ingress_out_en), 64'h0);
    check("rst_out", 64'(ingress_out), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    check("rst_err", 64'(sched_err), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: three words to VOQ 2, popped on three back-to-back grants
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h8000_0000 + k, 1'b0, '0, 1'b0);
    check("t1_occ2", 64'(occ(2)), 64'd3);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, '0, 1'b1, 2'd2, 1'b0);
      check($sformatf("t1_en%0d", k), 64'(ingress_out_en), 64'h1);
      check($sformatf("t1_data%0d", k), 64'(ingress_out), 64'(32'h8000_0000 + k));
    end
    idle();
    check("t1_en_low", 64'(ingress_out_en), 64'h0);
    check("t1_hold", 64'(ingress_out), 64'h8000_0003);
    check("t1_empty2", 64'(is_empty[2]), 64'h1);

    // 2: fill VOQ 1, then five overflow words
    for (int k = 0; k < D + 5; k++) step(1'b1, 32'h4000_0000 | k, 1'b0, '0, 1'b0);
    check("t2_full1", 64'(is_full[1]), 64'h1);
    check("t2_occ1", 64'(occ(1)), 64'd256);
    check("t2_drop", 64'(drop_cnt), 64'd5);
    check("t2_others", 64'({occ(0), occ(2), occ(3)}), 64'h0);

    // 3: VOQ 3 full, enqueue and grant same cycle
    for (int k = 0; k < D; k++) step(1'b1, 32'hC000_0000 | k, 1'b0, '0, 1'b0);
    step(1'b1, 32'hC000_1234, 1'b1, 2'd3, 1'b0);
    check("t3_en", 64'(ingress_out_en), 64'h1);
    check("t3_data", 64'(ingress_out), 64'hC000_0000);
    check("t3_drop", 64'(drop_cnt), 64'd6);
    check("t3_occ3", 64'(occ(3)), 64'd255);

    // 4: VOQ 0 empty, enqueue and grant same cycle
    step(1'b1, 32'h0000_00AA, 1'b1, 2'd0, 1'b0);
    check("t4_en", 64'(ingress_out_en), 64'h0);
    check("t4_err", 64'(sched_err), 64'h1);
    check("t4_occ0", 64'(occ(0)), 64'd1);

    // 5: streaming push/pop through VOQ 2 across two pointer wraps
    for (int k = 0; k < 2 * D + 3; k++)
      step(1'b1, 32'h8001_0000 + k, (k > 0), 2'd2, 1'b0);
    step(1'b0, '0, 1'b1, 2'd2, 1'b0);
    check("t5_last", 64'(ingress_out), 64'(32'h8001_0000 + 2 * D + 2));
    check("t5_occ2", 64'(occ(2)), 64'd0);

    // 6: one more drop, then flush with concurrent enqueue and grant
    step(1'b1, 32'h4000_FFFF, 1'b0, '0, 1'b0);
    check("t6_drop7", 64'(drop_cnt), 64'd7);
    check("t6_occ_pre", 64'({occ(0), occ(1), occ(3)}), {37'h0, 9'd1, 9'd256, 9'd255});
    step(1'b1, 32'h0000_0055, 1'b1, 2'd3, 1'b1);
    check("t6_occ", 64'(occupancy), 64'h0);
    check("t6_empty", 64'(is_empty), 64'hF);
    check("t6_drop", 64'(drop_cnt), 64'h0);
    check("t6_err", 64'(sched_err), 64'h0);
    check("t6_en", 64'(ingress_out_en), 64'h0);

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 3; k++) step(1'b1, 32'h8002_0000 + k, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 2'd1, 1'b0);
    ingress_in_en = 1'b1; ingress_in = 32'h8002_0009; sched_en = 1'b1; sched_sel = 2'd2;
    @(posedge clk);
    #1;
    check("ar_pre_en", 64'(ingress_out_en), 64'h1);
    check("ar_pre_err", 64'(sched_err), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("ar_en", 64'(ingress_out_en), 64'h0);
    check("ar_out", 64'(ingress_out), 64'h0);
    check("ar_empty", 64'(is_empty), 64'hF);
    check("ar_occ", 64'(occupancy), 64'h0);
    check("ar_err", 64'(sched_err), 64'h0);
    @(negedge clk);
    idle();
    idle();
    reset = 1'b0;
    idle();
    idle();
    check("post_empty", 64'(is_empty), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ingress_voq_ctrl.md
Name: ingress_voq_ctrl

Overview:
Parametrised ingress virtual-output-queue controller for one switch input port. It sorts incoming fixed-length metadata words into PORT_CNT per-egress VOQs held in one statically partitioned memory, and pops one word per grant from the scheduler toward the crossbar. Compared with the fixed 4-port ingress it adds:
- generic port count, depth and width
- explicit drop accounting on full
- per-VOQ occupancy reporting
- a single-cycle flush
- rejection and flagging of grants to empty queues

Parameters:
PORT_CNT, 4, number of egress ports / VOQs; power of two, >= 2
VOQ_DEPTH, 256, entries per VOQ; power of two, >= 2
META_WIDTH, 32, metadata word width; destination field is the top PW bits
DROP_CNT_W, 16, width of saturating drop counter
(derived: PW = $clog2(PORT_CNT), AW = $clog2(VOQ_DEPTH), CW = AW+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ingress_in  in  META_WIDTH  incoming metadata; dest = ingress_in[META_WIDTH-1 -: PW]
ingress_in_en  in  1  ingress_in valid this cycle
sched_en  in  1  scheduler grant: pop one word from VOQ sched_sel
sched_sel  in  PW  VOQ selected by scheduler
flush  in  1  synchronous clear of all VOQs and counters
ingress_out_en  out  1  ingress_out valid, one-cycle pulse per pop
ingress_out  out  META_WIDTH  popped metadata word to crossbar
is_empty  out  PORT_CNT  per-VOQ empty, to scheduler
is_full  out  PORT_CNT  per-VOQ full
occupancy  out  PORT_CNT*CW  flattened per-VOQ entry counts; VOQ i at [i*CW +: CW]
drop_cnt  out  DROP_CNT_W  words dropped because the target VOQ was full; saturating
sched_err  out  1  sticky; set on a grant to an empty VOQ

Behaviour:
- Reset (async assert, sync release):
  - all head/tail pointers and counts = 0
  - is_empty = all 1, is_full = all 0
  - ingress_out_en = 0, ingress_out = 0, drop_cnt = 0, sched_err = 0
- Per-VOQ state:
  - head[AW], tail[AW], count[CW]
  - memory address = {voq_index, ptr}, depth PORT_CNT*VOQ_DEPTH
  - pointers wrap naturally at VOQ_DEPTH (power of two)
- Status flags: is_empty[i] = (count==0) and is_full[i] = (count==VOQ_DEPTH), both decoded combinationally from registered counts.
- Enqueue:
  - Condition: ingress_in_en && !is_full[dest]. Write mem[{dest,tail}], tail++, count++.
  - If ingress_in_en && is_full[dest]: word discarded, drop_cnt++ saturating at all-ones.
- Dequeue:
  - Condition: sched_en && !is_empty[sched_sel]. Read mem[{sel,head}], head++, count--.
  - Next cycle: ingress_out_en = 1 with ingress_out = read data. Latency is exactly 1 cycle.
  - Otherwise ingress_out_en = 0. ingress_out holds its last value.
- Grant to empty VOQ: no pop, ingress_out_en = 0 next cycle, sched_err <= 1. sched_err is cleared only by reset or flush.
- Simultaneous enqueue and dequeue, same VOQ:
  - Both occur; count is unchanged.
  - Full VOQ: full is judged on the pre-cycle count, so the enqueue is dropped even though a pop occurs.
  - Empty VOQ: the grant is rejected (no bypass), sched_err sets, and the enqueue completes.
- Simultaneous events on different VOQs are independent. One enqueue and one dequeue per cycle maximum; memory is simple dual-port.
- Flush (highest priority after reset):
  - All pointers, counts, drop_cnt and sched_err = 0.
  - Same-cycle enqueue and dequeue are ignored; ingress_out_en = 0 next cycle.
  - Memory contents are not cleared.
- Back-to-back grants: one pop per cycle is sustained. ingress_out_en may stay high for consecutive cycles.

Decomposition:
- Package ingress_pkg: localparams PW/AW/CW derivation helpers; function dest_of(meta) returning the top PW bits.
- Sub-module voq_sram:
  - Parameters DEPTH, WIDTH.
  - Write port: we, waddr, wdata. Read port: re, raddr, rdata.
  - Registered read with 1-cycle latency; no reset on the array.
- Top level holds the pointer/count register arrays, flag decode, drop counter and output-valid register.

Test Plan:
1. Reset, then 3 enqueues with dest=2 (0x8000_0001..3), then grants sel=2 on 3 consecutive cycles -> ingress_out_en high 3 cycles, one cycle after each grant, data 0x8000_0001, 0x8000_0002, 0x8000_0003 in order; is_empty[2] returns to 1.
2. Fill VOQ 1 with VOQ_DEPTH words, then 5 more -> is_full[1]=1, occupancy[1]=256, drop_cnt=5; other VOQs unaffected.
3. VOQ 3 full, enqueue to 3 together with grant sel=3 -> pop delivered, enqueue dropped, drop_cnt+1, occupancy[3]=255.
4. VOQ 0 empty, enqueue to 0 together with grant sel=0 -> ingress_out_en=0, sched_err=1, occupancy[0]=1.
5. Push and pop VOQ 2 for 2*VOQ_DEPTH+3 words -> pointer wrap is correct and data order is preserved.
6. Occupancies nonzero and drop_cnt=7, pulse flush -> all counts 0, is_empty all 1, drop_cnt=0, sched_err=0. Assert reset mid-burst -> outputs take reset values immediately, without waiting for a clock edge.
